// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1/8N2 UART transmitter fed by a TX_DATA/TX_ENABLE strobe (optional parity via UART_TX_PARITY_EN)
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset (aborts any frame in progress)
//   TX_DATA    : byte to send, sampled only in the cycle TX_ENABLE is accepted
//   TX_ENABLE  : single-cycle send strobe, ignored while busy
//   TX_READY   : high = idle and able to accept a byte (registered)
//   txd        : serial line, idle high (registered)
//   UART_TX_PARITY_EN : when defined, a parity bit (even, or odd with PARITY_ODD=1) follows the data bits
module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_ENABLE,
  output logic       TX_READY,
  output logic       txd
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_serializer: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par, par_n;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic txd_n, ready_n, adv;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      txd <= 1'b1;
      TX_READY <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      txd <= txd_n;
      TX_READY <= ready_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
  // Next-state values are computed here and registered above, so every output
  // is a flop and no input reaches an output combinationally.
  always_comb begin
    state_n = state;
    idx_n = idx;
    shift_n = shift;
    txd_n = txd;
    ready_n = TX_READY;
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    adv = cnt == LAST;
    cnt_n = (state == IDLE || adv) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (TX_ENABLE) begin
        state_n = START;
        shift_n = TX_DATA;
        txd_n = 1'b0;
        ready_n = 1'b0;
        idx_n = '0;
`ifdef UART_TX_PARITY_EN
        par_n = ^TX_DATA ^ 1'(PARITY_ODD);
`endif
      end
      START: if (adv) begin
        state_n = DATA;
        txd_n = shift[0];
        shift_n = shift >> 1;
      end
      DATA: if (adv) begin
        if (idx == 3'd7) begin
          idx_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          txd_n = par;
`else
          state_n = STOP;
          txd_n = 1'b1;
`endif
        end else begin
          idx_n = idx + 3'd1;
          txd_n = shift[0];
          shift_n = shift >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (adv) begin
        state_n = STOP;
        txd_n = 1'b1;
      end
`endif
      STOP: if (adv) begin
        state_n = (idx == LAST_STOP) ? IDLE : STOP;
        ready_n = idx == LAST_STOP;
        idx_n = (idx == LAST_STOP) ? 3'd0 : idx + 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: frame-level model check of two transmitters (1 and 2 stop bits) sharing one stimulus
module tb_uart_tx_serializer;
  localparam int DIV = 4;
  localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clock = 1'b0, reset = 1'b1, en = 1'b0;
  logic [7:0] data = 8'h00;
  logic rdy1, txd1, rdy2, txd2;
  int tests = 0, fails = 0, rises1 = 0;
  logic prev1 = 1'b1;
  int pos [2] = '{-1, -1};
  logic [7:0] md [2];
  logic cap1 [64];
  logic cap2 [64];
  int low1, low2;
  always #5 clock = ~clock;
  uart_tx_serializer #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(250000), .STOP_BITS(1), .PARITY_ODD(PO)) u1 (
    .clock(clock), .reset(reset), .TX_DATA(data), .TX_ENABLE(en), .TX_READY(rdy1), .txd(txd1));
  uart_tx_serializer #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(250000), .STOP_BITS(2), .PARITY_ODD(PO)) u2 (
    .clock(clock), .reset(reset), .TX_DATA(data), .TX_ENABLE(en), .TX_READY(rdy2), .txd(txd2));
  function automatic int flen(input int sb);
    return (9 + P + sb) * DIV;
  endfunction
  function automatic logic fbit(input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (P == 1 && n == 9) return (^d) ^ (PO != 0);
    return 1'b1;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) pos[i] = -1;
      else if (pos[i] < 0) begin
        if (en) begin
          pos[i] = 0;
          md[i] = data;
        end
      end else begin
        pos[i]++;
        if (pos[i] == flen(i + 1)) pos[i] = -1;
      end
    end
    #1;
    chk("ready1", int'(rdy1), int'(pos[0] < 0));
    chk("txd1", int'(txd1), pos[0] < 0 ? 1 : int'(fbit(md[0], pos[0] / DIV)));
    chk("ready2", int'(rdy2), int'(pos[1] < 0));
    chk("txd2", int'(txd2), pos[1] < 0 ? 1 : int'(fbit(md[1], pos[1] / DIV)));
    if (rdy1 && !prev1) rises1++;
    prev1 = rdy1;
  end
  task automatic run_frame(input logic [7:0] d, input int ign_a, input int ign_b, input int rst_at);
    data = d;
    en = 1'b1;
    low1 = 0;
    low2 = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clock);
      en = 1'b0;
      data = 8'($urandom);
      if (j == rst_at + 1) reset = 1'b0;
      cap1[j] = txd1;
      cap2[j] = txd2;
      low1 += int'(!rdy1);
      low2 += int'(!rdy2);
      if (j == ign_a || j == ign_b) begin
        en = 1'b1;
        data = 8'hFF;
      end
      if (j == rst_at) begin
        reset = 1'b1;
        #1;
        chk("reset_txd1", int'(txd1), 1);
        chk("reset_ready1", int'(rdy1), 1);
        chk("reset_txd2", int'(txd2), 1);
        chk("reset_ready2", int'(rdy2), 1);
      end
    end
  endtask
  function automatic logic [7:0] decode1();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = cap1[DIV * (i + 1) + 2];
    return d;
  endfunction
  task automatic wait_rdy1();
    for (int k = 0; k < 200 && !rdy1; k++) @(negedge clock);
    chk("wait_ready1", int'(rdy1), 1);
  endtask
  initial begin
    logic [35:0] w;
    int run;
    int r0;
    logic [7:0] msg [3];
    msg = '{8'h48, 8'h69, 8'h0A};
    repeat (3) @(negedge clock);
    chk("reset_txd", int'(txd1), 1);
    chk("reset_ready", int'(rdy1), 1);
    reset = 1'b0;
    @(negedge clock);
    run_frame(8'h55, -1, -1, -1);
    for (int j = 0; j < 36; j++) w[j] = cap1[j];
    chk("t1_wave_55", int'(w == 36'h0F0F0F0F0), 1);
    chk("t1_low_1stop", low1, 40 + 4 * P);
    chk("t1_low_2stop", low2, 44 + 4 * P);
    chk("t1_idle_after", int'(cap1[40 + 4 * P]), 1);
    run_frame(8'h00, -1, -1, -1);
    run = 0;
    while (run < 60 && !cap2[run]) run++;
    chk("t2_low_run", run, 36 + 4 * P);
    chk("t2_low_2stop", low2, 44 + 4 * P);
    run_frame(8'hA3, 5, 20, -1);
    chk("t3_data_A3", int'(decode1()), 8'hA3);
    chk("t3_low_no_second", low1, 40 + 4 * P);
    run_frame(8'h0F, -1, -1, 17);
    run_frame(8'h81, -1, -1, -1);
    chk("t4_data_81", int'(decode1()), 8'h81);
    chk("t4_low", low1, 40 + 4 * P);
    r0 = rises1;
    for (int c = 0; c < 3; c++) begin
      wait_rdy1();
      data = msg[c];
      en = 1'b1;
      @(negedge clock);
      en = 1'b0;
      data = 8'($urandom);
    end
    wait_rdy1();
    chk("t6_ready_rises", rises1 - r0, 3);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      en = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      if (c == 700) reset = 1'b1;
      if (c == 702) reset = 1'b0;
    end
    en = 1'b0;
    repeat (60) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
